// File: rtl/queue_rr_arbiter.sv
// Front-end for the 8-entry queue: round-robin sharing of the enqueue port between
// two producers, plus sequencing of the queue's multi-cycle dequeue for one consumer.
module queue_rr_arbiter #(
    parameter int W       = 4,
    parameter int DEQ_LAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [W-1:0]     data0,
    input  logic             req1,
    input  logic [W-1:0]     data1,
    output logic             gnt0,
    output logic             gnt1,
    input  logic             pop_req,
    output logic             pop_valid,
    output logic [W-1:0]     pop_data,
    output logic             enq,
    output logic [W-1:0]     in,
    output logic             deq,
    input  logic [W-1:0]     out,
    input  logic             full,
    input  logic             empty,
    output logic             busy,
    output logic [CNT_W-1:0] gcnt0,
    output logic [CNT_W-1:0] gcnt1
);

    localparam int WCNT_W = (DEQ_LAT > 1) ? $clog2(DEQ_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAP
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  gcnt0_q, gcnt0_d;
    logic [CNT_W-1:0]  gcnt1_q, gcnt1_d;

    logic deq_start;
    logic eligible;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            last_q  <= 1'b1;
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            last_q  <= last_d;
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign deq_start = (state_q == S_IDLE) && pop_req && !empty;

    // NOTE: every signal gets a default at the top of the block so no latch is inferred.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (deq_start) begin
                    state_d = (DEQ_LAT == 1) ? S_CAP : S_WAIT;
                    wcnt_d  = WCNT_W'(DEQ_LAT - 1);
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q - WCNT_W'(1);
                if (wcnt_q == WCNT_W'(1)) begin
                    state_d = S_CAP;
                end
            end
            S_CAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are forced low during reset because the request inputs are not.
    always_comb begin
        deq       = !rst && deq_start;
        pop_valid = !rst && (state_q == S_CAP);
        busy      = !rst && (state_q != S_IDLE);
        pop_data  = out;
    end

    // Dequeue wins over enqueue, and the queue ignores enq while a dequeue is in flight.
    assign eligible = !rst && !full && !deq_start &&
                      ((state_q == S_IDLE) || (state_q == S_CAP));

    always_comb begin
        gnt0   = eligible && req0 && (!req1 || last_q);
        gnt1   = eligible && req1 && (!req0 || !last_q);
        enq    = gnt0 || gnt1;
        in     = gnt1 ? data1 : data0;
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        if (gnt0 && (gcnt0_q != '1)) begin
            gcnt0_d = gcnt0_q + CNT_W'(1);
        end
        if (gnt1 && (gcnt1_q != '1)) begin
            gcnt1_d = gcnt1_q + CNT_W'(1);
        end
    end

    assign gcnt0 = gcnt0_q;
    assign gcnt1 = gcnt1_q;

endmodule

// File: tb/tb_queue_rr_arbiter.sv
// Bench for queue_rr_arbiter: a behavioural 8-entry queue drives out/full/empty, and a
// cycle-phase reference model predicts grants, strobes, counters and popped data.
module tb_queue_rr_arbiter;

    localparam int W       = 4;
    localparam int DEQ_LAT = 2;
    localparam int CNT_W   = 8;
    localparam int DEPTH   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1, pop_req;
    logic [W-1:0]     data0, data1;
    logic             gnt0, gnt1, pop_valid, enq, deq, busy;
    logic [W-1:0]     pop_data, in, out;
    logic             full, empty;
    logic [CNT_W-1:0] gcnt0, gcnt1;

    always #5 clk = ~clk;

    queue_rr_arbiter #(.W(W), .DEQ_LAT(DEQ_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data),
        .enq(enq), .in(in), .deq(deq), .out(out),
        .full(full), .empty(empty), .busy(busy),
        .gcnt0(gcnt0), .gcnt1(gcnt1)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural queue: contents plus an output pipeline DEQ_LAT deep.
    logic [W-1:0] envq[$];
    logic [W-1:0] pipe_d[DEQ_LAT];
    logic         pipe_v[DEQ_LAT];

    // Reference model: phase = cycles since deq (0 = idle), last winner, grant totals.
    int           m_ph, m_last, m_c0, m_c1;
    logic [W-1:0] sb[$];
    logic [W-1:0] m_pend;

    logic             a_g0, a_g1, a_enq, a_deq, a_pv, a_busy;
    logic [W-1:0]     a_in, a_pd;
    logic [CNT_W-1:0] a_gc0, a_gc1;

    typedef struct {
        bit       rst_first;
        bit       r0;
        bit [3:0] d0;
        bit       r1;
        bit [3:0] d1;
        bit       pop;
        bit       g0, g1, dq, pv, bz;
        bit [3:0] pd;
    } vec_t;

    vec_t vt[17];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic env_flags();
        full  = (envq.size() == DEPTH);
        empty = (envq.size() == 0);
    endtask

    task automatic model_reset();
        m_ph   = 0;
        m_last = 1;
        m_c0   = 0;
        m_c1   = 0;
        sb.delete();
        envq.delete();
        for (int i = 0; i < DEQ_LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
        out = '0;
        env_flags();
    endtask

    task automatic step();
        int           cnt;
        logic         e_deq, e_elig, e_g0, e_g1, e_pv, e_busy;
        logic [W-1:0] popped;
        @(negedge clk);
        #1;
        cnt    = envq.size();
        a_g0   = gnt0;   a_g1 = gnt1;   a_enq = enq;  a_deq = deq;
        a_pv   = pop_valid; a_busy = busy; a_in = in; a_pd = pop_data;
        a_gc0  = gcnt0;  a_gc1 = gcnt1;

        e_deq  = !rst && (m_ph == 0) && pop_req && (cnt != 0);
        e_elig = !rst && ((m_ph == 0) || (m_ph == DEQ_LAT)) && (cnt < DEPTH) && !e_deq;
        e_g0   = e_elig && req0 && (!req1 || (m_last == 1));
        e_g1   = e_elig && req1 && (!req0 || (m_last == 0));
        e_pv   = !rst && (m_ph == DEQ_LAT);
        e_busy = !rst && (m_ph != 0);

        check("gnt0", a_g0, e_g0);
        check("gnt1", a_g1, e_g1);
        check("enq", a_enq, e_g0 | e_g1);
        check("in", a_in, e_g1 ? data1 : data0);
        check("deq", a_deq, e_deq);
        check("pop_valid", a_pv, e_pv);
        check("busy", a_busy, e_busy);
        check("gcnt0", a_gc0, m_c0);
        check("gcnt1", a_gc1, m_c1);
        if (e_pv) check("pop_data", a_pd, m_pend);

        if (e_deq && sb.size() > 0) m_pend = sb.pop_front();
        if (e_g0 || e_g1) sb.push_back(e_g1 ? data1 : data0);

        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            popped = '0;
            if (a_deq && envq.size() > 0) popped = envq.pop_front();
            for (int i = DEQ_LAT - 1; i > 0; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_d[i] = pipe_d[i-1];
            end
            pipe_v[0] = a_deq;
            pipe_d[0] = popped;
            if (pipe_v[DEQ_LAT-1]) out = pipe_d[DEQ_LAT-1];
            if (a_enq && envq.size() < DEPTH) envq.push_back(a_in);
            env_flags();

            if (e_deq)                 m_ph = 1;
            else if (m_ph == DEQ_LAT)  m_ph = 0;
            else if (m_ph != 0)        m_ph = m_ph + 1;
            if (e_g0) m_last = 0;
            if (e_g1) m_last = 1;
            if (e_g0 && m_c0 < CNT_MAX) m_c0++;
            if (e_g1 && m_c1 < CNT_MAX) m_c1++;
        end
    endtask

    task automatic set_in(input logic r0, input logic [W-1:0] d0,
                          input logic r1, input logic [W-1:0] d1, input logic pop);
        req0 = r0; data0 = d0; req1 = r1; data1 = d1; pop_req = pop;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, '0, 0, '0, 0);
        model_reset();
        step();
        check("rst gnt0", a_g0, 0);
        check("rst deq", a_deq, 0);
        check("rst busy", a_busy, 0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        int req_pct, pop_pct;

        vt[0]  = '{1, 1, 4'h3, 0, 4'h0, 0,  1, 0, 0, 0, 0, 4'h0};
        vt[1]  = '{0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 0, 0, 4'h0};
        vt[2]  = '{1, 1, 4'h5, 1, 4'hA, 0,  1, 0, 0, 0, 0, 4'h0};
        vt[3]  = '{0, 1, 4'h5, 1, 4'hA, 0,  0, 1, 0, 0, 0, 4'h0};
        vt[4]  = '{0, 1, 4'h5, 1, 4'hA, 0,  1, 0, 0, 0, 0, 4'h0};
        vt[5]  = '{0, 1, 4'h5, 1, 4'hA, 0,  0, 1, 0, 0, 0, 4'h0};
        vt[6]  = '{0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 1, 0, 0, 4'h0};
        vt[7]  = '{0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 0, 1, 4'h0};
        vt[8]  = '{0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 1, 1, 4'h5};
        vt[9]  = '{0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 0, 0, 4'h0};
        vt[10] = '{0, 1, 4'h7, 0, 4'h0, 1,  0, 0, 1, 0, 0, 4'h0};
        vt[11] = '{0, 1, 4'h7, 0, 4'h0, 0,  0, 0, 0, 0, 1, 4'h0};
        vt[12] = '{0, 1, 4'h7, 0, 4'h0, 0,  1, 0, 0, 1, 1, 4'hA};
        vt[13] = '{0, 0, 4'h0, 0, 4'h0, 1,  0, 0, 1, 0, 0, 4'h0};
        vt[14] = '{0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 0, 1, 4'h0};
        vt[15] = '{0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 1, 1, 4'h5};
        vt[16] = '{0, 0, 4'h0, 0, 4'h0, 0,  0, 0, 0, 0, 0, 4'h0};

        rst = 1'b1;
        set_in(0, '0, 0, '0, 0);
        model_reset();

        for (int i = 0; i < 17; i++) begin
            if (vt[i].rst_first) do_reset();
            set_in(vt[i].r0, vt[i].d0, vt[i].r1, vt[i].d1, vt[i].pop);
            step();
            check("vec gnt0", a_g0, vt[i].g0);
            check("vec gnt1", a_g1, vt[i].g1);
            check("vec deq", a_deq, vt[i].dq);
            check("vec pop_valid", a_pv, vt[i].pv);
            check("vec busy", a_busy, vt[i].bz);
            if (vt[i].pv) check("vec pop_data", a_pd, vt[i].pd);
            if (i == 1) check("vec gcnt0 after one grant", a_gc0, 1);
        end
        check("table gcnt0", a_gc0, 3);
        check("table gcnt1", a_gc1, 2);

        // Fill to capacity, then producer 1 must wait for a completed pop.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, W'(i + 1), 0, '0, 0);
            step();
            check("fill gnt0", a_g0, 1);
        end
        set_in(0, '0, 1, 4'hC, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("full gnt1", a_g1, 0);
        end
        pop_req = 1'b1;
        step();
        check("full deq", a_deq, 1);
        check("full deq gnt1", a_g1, 0);
        pop_req = 1'b0;
        step();
        check("full wait gnt1", a_g1, 0);
        step();
        check("full cap gnt1", a_g1, 1);
        check("full cap pop_data", a_pd, 1);
        set_in(0, '0, 0, '0, 0);
        step();

        // Pop on empty, then a late enqueue, then reset in the middle of a dequeue.
        do_reset();
        pop_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("empty deq", a_deq, 0);
            check("empty pop_valid", a_pv, 0);
        end
        set_in(1, 4'h9, 0, '0, 1);
        step();
        check("late enq gnt0", a_g0, 1);
        set_in(0, '0, 0, '0, 1);
        step();
        check("late deq", a_deq, 1);
        step();
        step();
        check("late pop_valid", a_pv, 1);
        check("late pop_data", a_pd, 4'h9);
        set_in(1, 4'h6, 0, '0, 0);
        step();
        set_in(0, '0, 0, '0, 1);
        step();
        check("pre-abort deq", a_deq, 1);
        pop_req = 1'b0;
        @(negedge clk);
        #1;
        check("pre-abort busy", busy, 1);
        rst = 1'b1;
        model_reset();
        #1;
        check("abort busy", busy, 0);
        check("abort deq", deq, 0);
        check("abort pop_valid", pop_valid, 0);
        check("abort enq", enq, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort no pop_valid", a_pv, 0);
        end
        rst = 1'b0;
        step();
        check("abort gcnt0", a_gc0, 0);

        // Producer 0 streams through the pop loop long enough to saturate its counter.
        do_reset();
        set_in(1, 4'h2, 0, '0, 1);
        for (int i = 0; i < 900; i++) begin
            step();
            if (a_g0) data0 = W'($urandom);
        end
        check("sat gcnt0", a_gc0, CNT_MAX);

        // Randomised traffic against the reference model.
        do_reset();
        set_in(0, '0, 0, '0, 0);
        for (int blk = 0; blk < 12; blk++) begin
            req_pct = $urandom_range(10, 95);
            pop_pct = $urandom_range(5, 90);
            for (int c = 0; c < 200; c++) begin
                step();
                if (!req0 || a_g0) begin
                    req0  = ($urandom_range(0, 99) < req_pct);
                    data0 = W'($urandom);
                end
                if (!req1 || a_g1) begin
                    req1  = ($urandom_range(0, 99) < req_pct);
                    data1 = W'($urandom);
                end
                pop_req = ($urandom_range(0, 99) < pop_pct);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/queue_rr_arbiter.md
Name: queue_rr_arbiter

Overview:
- Front-end controller for the 8-entry queue control unit (enq/deq/in/out/full/empty) and its register file.
- Shares the single enqueue port between two producers with round-robin arbitration.
- Sequences the queue's multi-cycle dequeue for one consumer, and never issues enq during the cycles the queue ignores it.
- Sits between the button/switch front-end (or test logic) and the queue; the display unit is unaffected.

Parameters:
- W, 4, data width; must match queue `in`/`out` width.
- DEQ_LAT, 2, cycles from the cycle in which deq is asserted until the queue's `out` holds the dequeued value. Minimum 1.
- CNT_W, 8, width of the per-producer grant counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0  in  1  producer 0 request; held with data0 until gnt0.
- data0  in  W  producer 0 data.
- req1  in  1  producer 1 request; held with data1 until gnt1.
- data1  in  W  producer 1 data.
- gnt0  out  1  producer 0 accepted at this rising edge (combinational).
- gnt1  out  1  producer 1 accepted at this rising edge (combinational).
- pop_req  in  1  consumer level request for one element.
- pop_valid  out  1  one-cycle pulse: pop_data is the dequeued element.
- pop_data  out  W  dequeued element; meaningful only when pop_valid=1.
- enq  out  1  to queue: enqueue strobe (combinational).
- in  out  W  to queue: enqueue data (combinational mux).
- deq  out  1  to queue: dequeue strobe (combinational).
- out  in  W  from queue: registered output data.
- full  in  1  from queue.
- empty  in  1  from queue.
- busy  out  1  dequeue sequence in progress (state != IDLE).
- gcnt0  out  CNT_W  saturating count of gnt0 pulses.
- gcnt1  out  CNT_W  saturating count of gnt1 pulses.

Behaviour:
- Reset:
  - Asynchronous; state=IDLE, last=1 (producer 0 wins the first tie), wait counter=0, gcnt0=gcnt1=0.
  - All strobe outputs are 0 while rst=1: gnt0, gnt1, enq, deq, pop_valid, busy.
  - Reset mid-sequence aborts it with no pop_valid; the queue is reset on the same rst.
- State machine: IDLE, WAIT, CAP.
  - IDLE: if pop_req && !empty, then deq=1 and next state is WAIT (or CAP when DEQ_LAT=1), loading the wait counter with DEQ_LAT-1. Otherwise stay in IDLE.
  - WAIT: deq=0; decrement the counter; go to CAP when the counter reaches 1.
  - CAP: pop_valid=1, pop_data=out (combinational pass-through); next state is IDLE unconditionally. No back-to-back deq from CAP, so peak pop rate is 1 per DEQ_LAT+1 cycles.
  - pop_req with empty=1: stay in IDLE, no deq, enqueues continue.
- Enqueue eligibility: state is IDLE or CAP, full=0, and deq=0 this cycle. Dequeue has priority over enqueue in the same cycle, and no enq is issued in WAIT.
- Arbitration, when eligible:
  - Only req0: grant 0. Only req1: grant 1.
  - Both: grant the producer != last. On a grant, last <= granted index.
  - enq = gnt0|gnt1; in = gnt1 ? data1 : data0 (data0 when neither is granted).
  - At most one gnt per cycle; gnt0&gnt1 is never 1. A grant implies the queue accepts the data at that edge.
- full/empty are taken from the queue as-is; one enqueue per cycle maximum, so registered-valid lag is safe.
- gcntX increments on each gntX and saturates at 2^CNT_W-1.
- pop_req dropped during WAIT/CAP: the sequence still completes and pop_valid still pulses. The consumer must accept that element.

Test Plan:
- Reset, then req0=1 data0=4'h3, one cycle: gnt0=1, enq=1, in=3 in that cycle; gcnt0=1; queue holds 3; last=0.
- req0=req1=1 held (data0=5, data1=A) for 4 cycles, queue empty: grants alternate 0,1,0,1; queue order 5,A,5,A; gcnt0=gcnt1=2.
- Queue holds 3,7, pop_req=1 at T0 with DEQ_LAT=2: deq=1 at T0, busy=1 at T1/T2, pop_valid=1 and pop_data=3 at T2, state IDLE at T3. Repeat yields 7.
- pop_req=1 and req0=1 in the same IDLE cycle, queue non-empty: deq=1, gnt0=0 in that cycle; gnt0=0 in WAIT; gnt0=1 in CAP.
- Fill to 8 entries, then req1=1: gnt1 stays 0 while full=1. After one pop completes, gnt1=1 in the next eligible cycle.
- Empty queue, pop_req=1 for 5 cycles: deq=0, pop_valid=0 throughout. Enqueue data0=9: deq asserts the cycle after, then pop_data=9. Assert rst in WAIT: outputs 0 immediately, no pop_valid.
